c1541_gcr_rw: RTL and testbench

C1541_GCR_RW -- requirements
Module: c1541_gcr_rw

---
 rtl/c1541_gcr_pkg.sv | 16 +
 rtl/c1541_bitcell_clk.sv | 53 +++++
 rtl/c1541_gcr_rw.sv | 166 ++++++++++++++++
 tb/tb_c1541_gcr_rw.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c1541_gcr_pkg.sv
// Shared constants and types for the 1541 GCR bit-cell read/write engine.
// Latency: n/a (definitions only); backpressure: n/a.
package c1541_gcr_pkg;

    localparam int SYNC_ONES      = 10;
    localparam int CELL_BASE      = 16;
    localparam int TICKS_PER_CELL = 4;

    typedef logic [1:0] zone_t;

    // Prescaler divide ratio for one quarter bit cell: 2*(16-zone) clk.
    function automatic logic [5:0] tick_div(input zone_t z);
        return 6'(2 * (CELL_BASE - int'(z)));
    endfunction

endpackage

// File: rtl/c1541_bitcell_clk.sv
// Bit-cell timebase: prescaler, phase counter, flux resync and mid-cell strobe.
// Latency: strobe two ticks after a resyncing flux edge; backpressure: none, halts while i_en=0.
module c1541_bitcell_clk
    import c1541_gcr_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_en,
    input  logic  i_clr,
    input  logic  i_rd,
    input  zone_t i_zone,
    input  logic  i_flux,
    output logic  o_edge,
    output logic  o_strobe
);

    localparam int PH_W = $clog2(TICKS_PER_CELL);
    localparam logic [PH_W-1:0] PH_MID = PH_W'(TICKS_PER_CELL / 2 - 1);

    logic [4:0]      r_presc;
    logic [5:0]      r_div;
    logic [PH_W-1:0] r_phase;
    logic            r_flux_d;
    logic            w_tick;

    // A flux edge restarts the cell and wins over a tick landing in the same clk.
    assign o_edge   = i_en & ~i_clr & i_rd & i_flux & ~r_flux_d;
    assign w_tick   = i_en & ({1'b0, r_presc} == (r_div - 6'd1));
    assign o_strobe = w_tick & ~o_edge & ~i_clr & (r_phase == PH_MID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= 5'd0;
            r_div    <= tick_div(2'd0);
            r_phase  <= '0;
            r_flux_d <= 1'b0;
        end else if (i_en) begin
            r_flux_d <= i_flux;
            if (i_clr || o_edge || w_tick) begin
                r_presc <= 5'd0;
                r_div   <= tick_div(i_zone);
            end else begin
                r_presc <= r_presc + 5'd1;
            end
            if (i_clr || o_edge) begin
                r_phase <= '0;
            end else if (w_tick) begin
                r_phase <= r_phase + PH_W'(1);
            end
        end
    end

endmodule

// File: rtl/c1541_gcr_rw.sv
// 1541 GCR read/write engine; the write path is compiled in only with C1541_GCR_WRITE_EN.
// Latency: byte_out/byte_ready one clk after the 8th mid-cell strobe; backpressure: none (soe gates byte_ready only).
module c1541_gcr_rw
    import c1541_gcr_pkg::*;
#(
    parameter int PULSE_LEN = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] zone,
    input  logic       mtr,
    input  logic       mode,
    input  logic       soe,
    input  logic       flux_in,
    input  logic [7:0] wr_data,
    output logic [7:0] byte_out,
    output logic       byte_ready,
    output logic       sync_n,
    output logic       wr_flux,
    output logic       wr_en
);

    localparam logic [3:0] SYNC_ONES_W = 4'(SYNC_ONES);

    logic       w_mode_eff;
    logic       w_mode_chg;
    logic       w_clr;
    logic       w_edge;
    logic       w_strobe;
    logic [3:0] w_ones_nxt;

    logic       r_mode_d;
    logic       r_pending;
    logic       r_sync_n;
    logic       r_byte_ready;
    logic [7:0] r_shift;
    logic [7:0] r_byte_out;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_ones;

`ifdef C1541_GCR_WRITE_EN
    localparam int PW = $clog2(PULSE_LEN + 1);

    logic [7:0]    r_wshift;
    logic [PW-1:0] r_pulse_cnt;
    logic          w_wbit;

    assign w_mode_eff = mode;
    // The first bit of a byte goes out straight from wr_data as it is loaded.
    assign w_wbit     = (r_bit_cnt == 3'd0) ? wr_data[7] : r_wshift[7];
    assign wr_en      = mtr & ~r_mode_d;
    assign wr_flux    = wr_en & (r_pulse_cnt != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse_cnt <= '0;
        end else if (mtr) begin
            if (w_clr) begin
                r_pulse_cnt <= '0;
            end else if (!w_mode_eff && w_strobe && w_wbit) begin
                r_pulse_cnt <= PW'(PULSE_LEN);
            end else if (r_pulse_cnt != '0) begin
                r_pulse_cnt <= r_pulse_cnt - PW'(1);
            end
        end
    end
`else
    logic w_unused;

    assign w_unused   = ^{mode, wr_data};
    assign w_mode_eff = 1'b1;
    assign wr_en      = 1'b0;
    assign wr_flux    = 1'b0;
`endif

    assign w_mode_chg = (w_mode_eff != r_mode_d);
    assign w_clr      = mtr & w_mode_chg;

    always_comb begin
        w_ones_nxt = 4'd0;
        if (r_pending) begin
            w_ones_nxt = (r_ones == 4'hF) ? 4'hF : r_ones + 4'd1;
        end
    end

    c1541_bitcell_clk u_bitcell (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_en     (mtr),
        .i_clr    (w_clr),
        .i_rd     (w_mode_eff),
        .i_zone   (zone),
        .i_flux   (flux_in),
        .o_edge   (w_edge),
        .o_strobe (w_strobe)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_d     <= 1'b1;
            r_pending    <= 1'b0;
            r_sync_n     <= 1'b1;
            r_byte_ready <= 1'b0;
            r_shift      <= 8'd0;
            r_byte_out   <= 8'd0;
            r_bit_cnt    <= 3'd0;
            r_ones       <= 4'd0;
`ifdef C1541_GCR_WRITE_EN
            r_wshift     <= 8'd0;
`endif
        end else begin
            r_byte_ready <= 1'b0;
            if (mtr) begin
                r_mode_d <= w_mode_eff;
                if (w_clr) begin
                    r_pending <= 1'b0;
                    r_sync_n  <= 1'b1;
                    r_shift   <= 8'd0;
                    r_bit_cnt <= 3'd0;
                    r_ones    <= 4'd0;
`ifdef C1541_GCR_WRITE_EN
                    r_wshift  <= 8'd0;
`endif
                end else if (w_mode_eff) begin
                    if (w_edge) begin
                        r_pending <= 1'b1;
                    end
                    if (w_strobe) begin
                        r_pending <= 1'b0;
                        r_shift   <= {r_shift[6:0], r_pending};
                        r_ones    <= w_ones_nxt;
                        if (r_pending && (w_ones_nxt >= SYNC_ONES_W)) begin
                            r_sync_n  <= 1'b0;
                            r_bit_cnt <= 3'd0;
                        end else if (!r_sync_n) begin
                            // The 0 that ends the sync mark is already bit 0 of the next byte.
                            r_sync_n  <= 1'b1;
                            r_bit_cnt <= 3'd1;
                        end else if (r_bit_cnt == 3'd7) begin
                            r_byte_out   <= {r_shift[6:0], r_pending};
                            r_byte_ready <= soe;
                            r_bit_cnt    <= 3'd0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
`ifdef C1541_GCR_WRITE_EN
                end else if (w_strobe) begin
                    if (r_bit_cnt == 3'd0) begin
                        r_wshift     <= {wr_data[6:0], 1'b0};
                        r_byte_ready <= soe;
                    end else begin
                        r_wshift <= {r_wshift[6:0], 1'b0};
                    end
                    r_bit_cnt <= r_bit_cnt + 3'd1;
`endif
                end
            end
        end
    end

    assign byte_out   = r_byte_out;
    assign byte_ready = r_byte_ready;
    assign sync_n     = r_sync_n;

endmodule

// File: tb/tb_c1541_gcr_rw.sv
// Self-checking bench for c1541_gcr_rw: sync detection, byte assembly, soe gating, reset abort and write path.
`timescale 1ns/1ps
module tb_c1541_gcr_rw;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] zone = 2'd0;
    logic       mtr = 1'b0;
    logic       mode = 1'b1;
    logic       soe = 1'b0;
    logic       flux_in = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic [7:0] byte_out;
    logic       byte_ready;
    logic       sync_n;
    logic       wr_flux;
    logic       wr_en;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         exp_cell_q[$];
    logic [7:0] obs_q[$];
    int         br_q[$];
    int         rise_q[$];
    int         width_q[$];
    int         rdy_cnt = 0;
    int         br_wide = 0;
    int         wr_seen_cnt = 0;
    int         rise_t = 0;
    logic       prev_br = 1'b0;
    logic       prev_flux = 1'b0;

    c1541_gcr_rw #(.PULSE_LEN(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .zone       (zone),
        .mtr        (mtr),
        .mode       (mode),
        .soe        (soe),
        .flux_in    (flux_in),
        .wr_data    (wr_data),
        .byte_out   (byte_out),
        .byte_ready (byte_ready),
        .sync_n     (sync_n),
        .wr_flux    (wr_flux),
        .wr_en      (wr_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation side of the scoreboard: captures what the DUT produced.
    always @(negedge clk) begin
        if (byte_ready) begin
            obs_q.push_back(byte_out);
            br_q.push_back(cyc);
            rdy_cnt = rdy_cnt + 1;
            if (prev_br) br_wide = br_wide + 1;
        end
        prev_br = byte_ready;
        if (wr_flux && !prev_flux) begin
            rise_q.push_back(cyc);
            rise_t = cyc;
        end
        if (!wr_flux && prev_flux) width_q.push_back(cyc - rise_t);
        prev_flux = wr_flux;
        if (wr_en || wr_flux) wr_seen_cnt = wr_seen_cnt + 1;
    end

    task automatic start(input logic mode_v, input logic [1:0] zone_v, input logic soe_v);
        mtr = 1'b0;
        flux_in = 1'b0;
        mode = mode_v;
        zone = zone_v;
        soe = soe_v;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        mtr = 1'b1;
    endtask

    task automatic send_cell(input logic b);
        int cl;
        cl = 8 * (16 - int'(zone));
        for (int j = 0; j < cl; j++) begin
            @(posedge clk);
            #1 flux_in = b && (j < 2);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_cell(v[i]);
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) send_cell(1'b1);
    endtask

    task automatic test_reset();
        mtr = 1'b1;
        mode = 1'b0;
        soe = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL rst_byte_out: got %h want 00", byte_out); end
        n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL rst_byte_ready: got %b want 0", byte_ready); end
        n_checks++; if (sync_n !== 1'b1) begin n_fail++; $display("FAIL rst_sync_n: got %b want 1", sync_n); end
        n_checks++; if (wr_flux !== 1'b0) begin n_fail++; $display("FAIL rst_wr_flux: got %b want 0", wr_flux); end
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        mtr = 1'b0;
        mode = 1'b1;
    endtask

    task automatic test_sync();
        int d;
        start(1'b1, 2'd0, 1'b1);
        d = 2 * 16;
        send_ones(9);
        for (int j = 0; j < 4 * d; j++) begin
            @(posedge clk);
            #1 flux_in = (j < 2);
            if (j == 2 * d) begin
                n_checks++; if (sync_n !== 1'b1) begin n_fail++; $display("FAIL sync_before_10th: got %b want 1", sync_n); end
            end
            if (j == 2 * d + 1) begin
                n_checks++; if (sync_n !== 1'b0) begin n_fail++; $display("FAIL sync_fall_10th: got %b want 0", sync_n); end
            end
        end
        send_ones(2);
        n_checks++; if (sync_n !== 1'b0) begin n_fail++; $display("FAIL sync_hold: got %b want 0", sync_n); end
        for (int j = 0; j < 4 * d; j++) begin
            @(posedge clk);
            #1 flux_in = 1'b0;
            if (j == 2 * d) begin
                n_checks++; if (sync_n !== 1'b0) begin n_fail++; $display("FAIL sync_before_zero: got %b want 0", sync_n); end
            end
            if (j == 2 * d + 1) begin
                n_checks++; if (sync_n !== 1'b1) begin n_fail++; $display("FAIL sync_rise_zero: got %b want 1", sync_n); end
            end
        end
        mtr = 1'b0;
    endtask

    task automatic test_byte(input logic soe_v, input logic mode_v, input logic [7:0] v);
        int base, r0, w0, ws0, k;
        start(mode_v, 2'd3, soe_v);
        send_ones(12);
        n_checks++; if (sync_n !== 1'b0) begin n_fail++; $display("FAIL byte_presync: got %b want 0", sync_n); end
        base = obs_q.size();
        r0 = rdy_cnt;
        w0 = br_wide;
        ws0 = wr_seen_cnt;
        if (soe_v) exp_q.push_back(v);
        send_byte(v);
        repeat (3) send_cell(1'b0);
        mtr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        k = 0;
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (base + k >= obs_q.size()) begin
                n_fail++; $display("FAIL byte_missing: got none want %h", e);
            end else if (obs_q[base + k] !== e) begin
                n_fail++; $display("FAIL byte_value: got %h want %h", obs_q[base + k], e);
            end
            k++;
        end
        n_checks++; if (rdy_cnt - r0 != (soe_v ? 1 : 0)) begin n_fail++; $display("FAIL byte_ready_count: got %0d want %0d", rdy_cnt - r0, soe_v ? 1 : 0); end
        n_checks++; if (br_wide != w0) begin n_fail++; $display("FAIL byte_ready_width: got %0d long pulses want 0", br_wide - w0); end
        n_checks++; if (byte_out !== v) begin n_fail++; $display("FAIL byte_out_hold: got %h want %h", byte_out, v); end
        n_checks++; if (sync_n !== 1'b1) begin n_fail++; $display("FAIL byte_sync_after: got %b want 1", sync_n); end
        if (!mode_v) begin
            n_checks++; if (wr_seen_cnt != ws0) begin n_fail++; $display("FAIL readonly_wr: got %0d active cycles want 0", wr_seen_cnt - ws0); end
        end
    endtask

    task automatic test_reset_mid();
        int base, r0, k;
        start(1'b1, 2'd3, 1'b1);
        send_ones(12);
        send_cell(1'b0); send_cell(1'b1); send_cell(1'b0); send_cell(1'b1); send_cell(1'b0);
        for (int j = 0; j < 50; j++) begin
            @(posedge clk);
            #1 flux_in = 1'b0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_byte_out: got %h want 00", byte_out); end
        n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_byte_ready: got %b want 0", byte_ready); end
        n_checks++; if (sync_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_sync_n: got %b want 1", sync_n); end
        n_checks++; if ((wr_flux | wr_en) !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr: got %b%b want 00", wr_flux, wr_en); end
        reset_n = 1'b1;
        r0 = rdy_cnt;
        repeat (4) send_cell(1'b0);
        n_checks++; if (rdy_cnt != r0) begin n_fail++; $display("FAIL mid_rst_no_ready: got %0d want 0", rdy_cnt - r0); end
        send_ones(12);
        base = obs_q.size();
        exp_q.push_back(8'h49);
        send_byte(8'h49);
        repeat (3) send_cell(1'b0);
        mtr = 1'b0;
        @(posedge clk);
        #1;
        k = 0;
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (base + k >= obs_q.size()) begin
                n_fail++; $display("FAIL mid_rst_byte_missing: got none want %h", e);
            end else if (obs_q[base + k] !== e) begin
                n_fail++; $display("FAIL mid_rst_byte: got %h want %h", obs_q[base + k], e);
            end
            k++;
        end
        n_checks++; if (obs_q.size() != base + k) begin n_fail++; $display("FAIL mid_rst_extra: got %0d bytes want %0d", obs_q.size() - base, k); end
    endtask

`ifdef C1541_GCR_WRITE_EN
    task automatic test_write();
        int rb, wb, bb, n, c, i;
        logic got;
        wr_data = 8'hFF;
        start(1'b0, 2'd2, 1'b1);
        rb = rise_q.size();
        wb = width_q.size();
        bb = br_q.size();
        for (int k = 0; k < 8; k++) exp_cell_q.push_back(k);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL wr_en_on: got %b want 1", wr_en); end
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(posedge clk);
            #1 if (byte_ready) got = 1'b1;
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL wr_load0: got no byte_ready want one within 400 clk"); end
        wr_data = 8'h55;
        for (int k = 9; k < 16; k += 2) exp_cell_q.push_back(k);
        got = 1'b0;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(posedge clk);
            #1 if (byte_ready) got = 1'b1;
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL wr_load1: got no byte_ready want one within 1000 clk"); end
        wr_data = 8'h00;
        repeat (840) @(posedge clk);
        #1 mtr = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if ((wr_en | wr_flux) !== 1'b0) begin n_fail++; $display("FAIL wr_mtr_off: got %b%b want 00", wr_en, wr_flux); end
        n = exp_cell_q.size();
        n_checks++; if (rise_q.size() - rb != n) begin n_fail++; $display("FAIL wr_pulse_count: got %0d want %0d", rise_q.size() - rb, n); end
        i = 0;
        while (exp_cell_q.size() > 0) begin
            c = exp_cell_q.pop_front();
            if (rb + i < rise_q.size()) begin
                n_checks++; if (rise_q[rb + i] - rise_q[rb] != c * 112) begin n_fail++; $display("FAIL wr_pulse_time[%0d]: got %0d want %0d", i, rise_q[rb + i] - rise_q[rb], c * 112); end
            end
            if (wb + i < width_q.size()) begin
                n_checks++; if (width_q[wb + i] != 8) begin n_fail++; $display("FAIL wr_pulse_width[%0d]: got %0d want 8", i, width_q[wb + i]); end
            end
            i++;
        end
        n_checks++; if (br_q.size() - bb != 2) begin n_fail++; $display("FAIL wr_load_count: got %0d want 2", br_q.size() - bb); end
        if (br_q.size() - bb >= 2 && rise_q.size() > rb) begin
            n_checks++; if (br_q[bb] != rise_q[rb]) begin n_fail++; $display("FAIL wr_load0_time: got %0d want %0d", br_q[bb], rise_q[rb]); end
            n_checks++; if (br_q[bb + 1] - rise_q[rb] != 8 * 112) begin n_fail++; $display("FAIL wr_load1_time: got %0d want %0d", br_q[bb + 1] - rise_q[rb], 8 * 112); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sync();
        test_byte(1'b1, 1'b1, 8'h52);
        test_byte(1'b0, 1'b1, 8'h52);
        test_reset_mid();
`ifdef C1541_GCR_WRITE_EN
        test_write();
`else
        test_byte(1'b1, 1'b0, 8'h52);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
